// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-port MMIO arbiter.
package mmio_arb_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mmio_arbiter_if.sv
// Requester and memory-side signals of the MMIO arbiter, bundled for port use.
interface mmio_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);

   // Handshake: a requester raises reqN with wrenN/addrN/wdataN and holds them
   // stable until gntN=1; the access is accepted in that very cycle. reqN may
   // drop without a grant. A granted read returns rdata with rvalidN one cycle later.
   logic              req0,   req1;
   logic              wren0,  wren1;
   logic              lock0,  lock1;
   logic [ADDR_W-1:0] addr0,  addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0,   gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output req0, req1, wren0, wren1, lock0, lock1,
      output addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata
   );

   modport slave (
      input  req0, req1, wren0, wren1, lock0, lock1,
      input  addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
      output mem_addr, mem_wdata, mem_wren
   );

   modport mem (
      input  mem_addr, mem_wdata, mem_wren,
      output mem_rdata
   );

endinterface

// File: rtl/mmio_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; on contention the port that did not win last goes.
module rr_pick2
   import mmio_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       winner
);

   always_comb begin
      gnt    = 2'b00;
      winner = last;
      case (req)
         2'b01: begin
            gnt    = 2'b01;
            winner = P0;
         end
         2'b10: begin
            gnt    = 2'b10;
            winner = P1;
         end
         2'b11: begin
            if (last == P1) begin
               gnt    = 2'b01;
               winner = P0;
            end else begin
               gnt    = 2'b10;
               winner = P1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing the MMIO port between processor (port 0) and engine (port 1).
// Define MMIO_ARB_LOCK_EN to enable bounded locked bursts (LOCKED state, MAX_LOCK).
module mmio_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_LOCK = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   mmio_arbiter_if.slave                 bus,
   output arb_state_e                    dbg_state,
   output logic [$clog2(MAX_LOCK+1)-1:0] dbg_count
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   logic              last;
   logic [1:0]        pick_gnt;
   logic              pick_win;
   logic [1:0]        gnt_v;
   logic              any_gnt;
   logic [1:0]        rd_v;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;
   logic              rvalid0_q, rvalid1_q;
   logic [DATA_W-1:0] rdata_q;

   rr_pick2 u_pick (
      .req    ({bus.req1, bus.req0}),
      .last   (last),
      .gnt    (pick_gnt),
      .winner (pick_win)
   );

`ifdef MMIO_ARB_LOCK_EN
   arb_state_e       state;
   logic             owner;
   logic [CNT_W-1:0] count;
   logic             win_lock;
   logic             owner_req;
   logic             owner_lock;

   assign win_lock   = (pick_win == P1) ? bus.lock1 : bus.lock0;
   assign owner_req  = (owner == P1) ? bus.req1 : bus.req0;
   assign owner_lock = (owner == P1) ? bus.lock1 : bus.lock0;

   always_comb begin
      gnt_v = pick_gnt;
      if (state == LOCKED) gnt_v = (owner == P1) ? {bus.req1, 1'b0} : {1'b0, bus.req0};
      if (reset) gnt_v = 2'b00;
   end

   // Releasing hands `last` to the owner so the other port wins the next contest.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ARB;
         last  <= P1;
         owner <= P0;
         count <= '0;
      end else begin
         case (state)
            ARB: begin
               if (any_gnt) begin
                  last <= pick_win;
                  if (win_lock && (MAX_LOCK > 1)) begin
                     state <= LOCKED;
                     owner <= pick_win;
                     count <= CNT_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (owner_req) begin
                  last <= owner;
                  if (!owner_lock || (count >= CNT_W'(MAX_LOCK - 1))) begin
                     state <= ARB;
                     count <= '0;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end else if (!owner_lock) begin
                  state <= ARB;
                  count <= '0;
                  last  <= owner;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   assign dbg_state = state;
   assign dbg_count = count;
`else
   always_comb begin
      gnt_v = pick_gnt;
      if (reset) gnt_v = 2'b00;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last <= P1;
      end else if (any_gnt) begin
         last <= pick_win;
      end
   end

   assign dbg_state = ARB;
   assign dbg_count = '0;
`endif

   assign any_gnt  = |gnt_v;
   assign bus.gnt0 = gnt_v[0];
   assign bus.gnt1 = gnt_v[1];

   // With no grant the memory port sees zeros rather than a stale requester.
   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      if (gnt_v[0]) begin
         addr_sel  = bus.addr0;
         wdata_sel = bus.wdata0;
      end else if (gnt_v[1]) begin
         addr_sel  = bus.addr1;
         wdata_sel = bus.wdata1;
      end
   end

   assign bus.mem_addr  = addr_sel;
   assign bus.mem_wdata = wdata_sel;
   assign bus.mem_wren  = (gnt_v[0] & bus.wren0) | (gnt_v[1] & bus.wren1);

   assign rd_v = {gnt_v[1] & ~bus.wren1, gnt_v[0] & ~bus.wren0};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rvalid0_q <= rd_v[0];
         rvalid1_q <= rd_v[1];
         if (|rd_v) rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: routing, round-robin, read return, async reset, lock mode.
module tb_mmio_arbiter;
  import mmio_arb_pkg::*;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 32;
  localparam int MAX_LOCK = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mmio_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  arb_state_e dbg_state;
  logic [3:0] dbg_count;

  mmio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    bus.req0 = 1'b0; bus.wren0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.wren1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic drive0(input logic wr, input logic lk, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req0 = 1'b1; bus.wren0 = wr; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input logic wr, input logic lk, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req1 = 1'b1; bus.wren1 = wr; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e0;
    logic e1;
    reset = 1'b1;
    idle();
    bus.mem_rdata = '0;
    drive0(1'b1, 1'b0, 13'h0005, 32'h1);

    // reset state: request present but blocked
    @(negedge clock); #1;
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_mem_wren", bus.mem_wren, 1'b0);
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_state", dbg_state, ARB);
    idle();
    reset = 1'b0;

    // contention right after reset: 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive0(1'b1, 1'b0, 13'h0100, 32'h000000A0);
      drive1(1'b1, 1'b0, 13'h0200, 32'h000000B1);
      #1;
      e0 = (k % 2 == 0);
      chk("cont_gnt0", bus.gnt0, e0);
      chk("cont_gnt1", bus.gnt1, !e0);
      chk("cont_addr", bus.mem_addr, e0 ? 13'h0100 : 13'h0200);
      chk("cont_wdata", bus.mem_wdata, e0 ? 32'h000000A0 : 32'h000000B1);
    end

    @(negedge clock); idle(); #1;
    chk("none_gnt0", bus.gnt0, 1'b0);
    chk("none_gnt1", bus.gnt1, 1'b0);
    chk("none_wren", bus.mem_wren, 1'b0);
    chk("none_addr", bus.mem_addr, 13'h0);
    chk("wr_no_rvalid0", bus.rvalid0, 1'b0);
    chk("wr_no_rvalid1", bus.rvalid1, 1'b0);

    // single read on port 0
    @(negedge clock);
    drive0(1'b0, 1'b0, 13'h0010, 32'hAAAA5555);
    bus.mem_rdata = 32'h12345678;
    exp_q.push_back(32'h12345678);
    #1;
    chk("rd0_gnt0", bus.gnt0, 1'b1);
    chk("rd0_gnt1", bus.gnt1, 1'b0);
    chk("rd0_addr", bus.mem_addr, 13'h0010);
    chk("rd0_wren", bus.mem_wren, 1'b0);
    chk("rd0_wdata", bus.mem_wdata, 32'hAAAA5555);
    @(negedge clock); idle(); #1;
    chk("rd0_rvalid0", bus.rvalid0, 1'b1);
    chk("rd0_rvalid1", bus.rvalid1, 1'b0);
    chk("rd0_rdata", bus.rdata, exp_q.pop_front());
    @(negedge clock); #1;
    chk("rd0_rvalid0_drop", bus.rvalid0, 1'b0);

    // write routing on port 1
    @(negedge clock);
    drive1(1'b1, 1'b0, 13'h1FFF, 32'hDEADBEEF);
    #1;
    chk("wr1_gnt1", bus.gnt1, 1'b1);
    chk("wr1_gnt0", bus.gnt0, 1'b0);
    chk("wr1_wren", bus.mem_wren, 1'b1);
    chk("wr1_addr", bus.mem_addr, 13'h1FFF);
    chk("wr1_wdata", bus.mem_wdata, 32'hDEADBEEF);
    @(negedge clock); idle(); #1;
    chk("wr1_no_rvalid1", bus.rvalid1, 1'b0);

    // read on port 1
    @(negedge clock);
    drive1(1'b0, 1'b0, 13'h0ABC, 32'h0);
    bus.mem_rdata = 32'hCAFEF00D;
    exp_q.push_back(32'hCAFEF00D);
    #1;
    chk("rd1_gnt1", bus.gnt1, 1'b1);
    chk("rd1_addr", bus.mem_addr, 13'h0ABC);
    @(negedge clock); idle(); #1;
    chk("rd1_rvalid1", bus.rvalid1, 1'b1);
    chk("rd1_rvalid0", bus.rvalid0, 1'b0);
    chk("rd1_rdata", bus.rdata, exp_q.pop_front());

`ifndef MMIO_ARB_LOCK_EN
    // lock inputs have no effect: plain alternation, last winner was port 1
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      drive0(1'b1, 1'b1, 13'h0111, 32'h11);
      drive1(1'b1, 1'b1, 13'h0222, 32'h22);
      #1;
      e0 = (k % 2 == 0);
      chk("nolock_gnt0", bus.gnt0, e0);
      chk("nolock_gnt1", bus.gnt1, !e0);
      chk("nolock_state", dbg_state, ARB);
    end
`endif

    // async reset with a read in flight; port 0 won last, reset must restore port 0 priority
    @(negedge clock); idle();
    drive0(1'b0, 1'b0, 13'h0020, 32'h0);
    bus.mem_rdata = 32'h55AA55AA;
    #1;
    chk("rstf_gnt0", bus.gnt0, 1'b1);
    @(posedge clock); #2;
    chk("rstf_inflight", bus.rvalid0, 1'b1);
    idle();
    drive0(1'b1, 1'b0, 13'h0030, 32'h30);
    drive1(1'b1, 1'b0, 13'h0031, 32'h31);
    reset = 1'b1;
    #1;
    chk("rstf_rvalid0", bus.rvalid0, 1'b0);
    chk("rstf_rdata", bus.rdata, 32'h0);
    chk("rstf_gnt0_held", bus.gnt0, 1'b0);
    chk("rstf_gnt1_held", bus.gnt1, 1'b0);
    chk("rstf_wren_held", bus.mem_wren, 1'b0);
    @(negedge clock); reset = 1'b0; #1;
    chk("rstf_first_gnt0", bus.gnt0, 1'b1);
    chk("rstf_first_gnt1", bus.gnt1, 1'b0);

`ifdef MMIO_ARB_LOCK_EN
    // fresh reset, then port 1 locks while both requesters stay busy
    @(negedge clock); idle();
    reset = 1'b1; #1; reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      drive0(1'b1, 1'b0, 13'h0300, DATA_W'(k));
      drive1(1'b1, 1'b1, 13'h0301, DATA_W'(k));
      #1;
      e1 = ((k >= 1) && (k <= 8)) || (k == 10);
      chk("lockb_gnt1", bus.gnt1, e1);
      chk("lockb_gnt0", bus.gnt0, !e1);
      if (k == 5) begin
        chk("lockb_state", dbg_state, LOCKED);
        chk("lockb_count", dbg_count, 4'd4);
      end
      if (k == 9) chk("lockb_released", dbg_state, ARB);
    end
    @(negedge clock); idle(); #1;
    chk("lockb_idle_gnt1", bus.gnt1, 1'b0);
    @(negedge clock); #1;
    chk("lockb_idle_state", dbg_state, ARB);

    // port 0 locks, idles with lock held, then releases
    @(negedge clock);
    drive0(1'b1, 1'b1, 13'h0400, 32'h40);
    drive1(1'b1, 1'b0, 13'h0401, 32'h41);
    #1;
    chk("lockr_gnt0", bus.gnt0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      bus.req0 = 1'b0;
      #1;
      chk("lockr_hold_gnt1", bus.gnt1, 1'b0);
      chk("lockr_hold_gnt0", bus.gnt0, 1'b0);
    end
    @(negedge clock);
    bus.lock0 = 1'b0;
    #1;
    chk("lockr_rel_gnt1", bus.gnt1, 1'b0);
    @(negedge clock); #1;
    chk("lockr_after_gnt1", bus.gnt1, 1'b1);

    // reset while port 1 holds a lock with its read in flight
    @(negedge clock); idle();
    drive1(1'b0, 1'b1, 13'h0055, 32'h0);
    bus.mem_rdata = 32'h0BADF00D;
    #1;
    chk("lockx_gnt1", bus.gnt1, 1'b1);
    @(posedge clock); #2;
    chk("lockx_state", dbg_state, LOCKED);
    chk("lockx_inflight", bus.rvalid1, 1'b1);
    idle();
    drive0(1'b1, 1'b0, 13'h0060, 32'h60);
    drive1(1'b1, 1'b0, 13'h0061, 32'h61);
    reset = 1'b1;
    #1;
    chk("lockx_rvalid1", bus.rvalid1, 1'b0);
    chk("lockx_rdata", bus.rdata, 32'h0);
    chk("lockx_rst_state", dbg_state, ARB);
    chk("lockx_rst_count", dbg_count, 4'd0);
    chk("lockx_rst_gnt1", bus.gnt1, 1'b0);
    @(negedge clock); reset = 1'b0; #1;
    chk("lockx_first_gnt0", bus.gnt0, 1'b1);
    chk("lockx_first_gnt1", bus.gnt1, 1'b0);
`endif

    @(negedge clock); idle();
    repeat (2) @(negedge clock);
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-port round-robin arbiter sharing the single memory-mapped I/O port (data memory, controller GPIO registers, VGA player registers) between the processor and a second bus master (the VGA/sprite update engine). It sits between the requesters and the mmio block, multiplexes address/write data/write enable onto the memory port, and routes read data back to the owner with a one-cycle-later valid strobe. An optional lock mode gives one master a bounded burst of back-to-back accesses.

## Interface
Parameters:
- ADDR_W, 13, mmio address width
- DATA_W, 32, data width
- MAX_LOCK, 8, maximum consecutive locked grants to one port (≥1)

Ports:
- clock  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request from port 0 (processor) / port 1 (engine)
- wren0 / wren1  in  1  write (1) or read (0)
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  hold ownership after this access (only with lock feature)
- gnt0 / gnt1  out  1  combinational: request accepted this cycle
- rvalid0 / rvalid1  out  1  registered: read data valid for that port
- rdata  out  DATA_W  registered read data (shared, qualified by rvalid*)
- mem_addr  out  ADDR_W  to mmio address
- mem_wdata  out  DATA_W  to mmio data_in
- mem_wren  out  1  to mmio wren
- mem_rdata  in  DATA_W  from mmio data_out; valid one cycle after address issue

## Operation
- Every access is single-cycle issue: in the cycle gntN=1, mem_* carry port N's addr/wdata/wren.
- No grant: mem_wren=0, mem_addr/mem_wdata=0.
- Arbitration per cycle: one requester → grant it; both → grant the port that did not win last (pointer `last`); neither → no grant, `last` unchanged.
- `last` resets to 1 so port 0 wins the first contested cycle.
- Reads: a granted read sets rvalidN=1 next cycle with rdata=mem_rdata captured that cycle. Writes never raise rvalid.
- Requester holds req/addr/wdata/wren stable until it sees gnt; req may drop without a grant (no penalty).
- FSM (lock feature): ARB (normal round-robin) and LOCKED (owner, count).
  - ARB→LOCKED when granted port has lockN=1; owner=that port, count=1.
  - In LOCKED: only owner can be granted; other port's req is ignored (gnt=0).
  - Each owner grant with lock still high and count<MAX_LOCK: count+1, stay.
  - Owner grant with lock low, or count reaches MAX_LOCK, or owner req=0 with lock=0: →ARB, `last`=owner (so the other port wins the next contested cycle).
  - Owner req=0 but lock=1: stay LOCKED, idle cycle, count unchanged.
- gnt0 and gnt1 are never both 1.

## Timing
- Grant latency: 0 cycles (combinational from req and state). Read data latency: 1 cycle after grant.
- Throughput: one access per cycle; alternating contested accesses give each port 1 of 2 cycles.
- Reset (async, any time, including mid-lock or with read in flight): state=ARB, last=1, count=0, rvalid0/1=0, rdata=0; gnt0/1=0 and mem_wren=0 while reset=1. In-flight read data is discarded.
- Release from LOCKED takes effect the cycle after the releasing grant.

## Configuration
- MMIO_ARB_LOCK_EN defined: lock0/lock1 honoured, LOCKED state and count present.
- Not defined: lock inputs ignored (ports remain, unconnected internally), pure round-robin, no LOCKED state; MAX_LOCK unused.

## Structure
- Shared package mmio_arb_pkg: state enum (ARB, LOCKED), port-index constants P0=0/P1=1, default ADDR_W/DATA_W.
- One sub-module natural: rr_pick2 (combinational two-way round-robin pick from req vector and `last`). FSM, counter and read-return pipe in the top.

## Test plan
- Single requester: req0 read addr 0x0010 alone → gnt0 same cycle, mem_addr=0x0010, rvalid0 next cycle with rdata=mem_rdata; rvalid1 stays 0.
- Contention: req0 and req1 both held 4 cycles → grants 0,1,0,1; after reset first contested grant goes to port 0.
- Write routing: req1 write addr 0x1FFF data 0xDEADBEEF → mem_wren=1, mem_wdata=0xDEADBEEF that cycle, no rvalid1.
- Lock bound (LOCK_EN, MAX_LOCK=8): port1 locked with req0/req1 held → eight consecutive gnt1, then gnt0, then gnt1.
- Lock release/idle (LOCK_EN): port0 locks, drops req with lock=1 for 2 cycles → no grants to port1; lock=0 → port1 granted next cycle.
- Async reset mid-lock with read in flight → rvalid0/1=0, rdata=0 immediately; after release, contested cycle grants port 0.
